// File: rtl/freq_meter_pkg.sv
// Shared constants for the gated frequency meter: FSM state encodings and the default clock rate.
package freq_meter_pkg;

   localparam int DEFAULT_CLK_HZ = 100_000_000;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_GATE = 1'b1;

endpackage

// File: rtl/freq_meter_sig_sync_edge.sv
// sig_sync_edge: 2-flop synchronizer, optional glitch filter (FREQ_METER_GLITCH_FILTER_EN), rising-edge detect.
// o_rise is high for 1 clk; the edge counter sees it 3 clks after sampling (4 with the filter).
module sig_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic sync1;
   logic sync2;
   logic level_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= i_async;
         sync2 <= sync1;
      end
   end

`ifdef FREQ_METER_GLITCH_FILTER_EN
   logic sync2_d;

   // The level only follows sync2 once it has held the same value on two consecutive clks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync2_d <= 1'b0;
         o_level <= 1'b0;
      end else begin
         sync2_d <= sync2;
         if (sync2 == sync2_d)
            o_level <= sync2;
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         o_level <= 1'b0;
      else
         o_level <= sync2;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         level_d <= 1'b0;
      else
         level_d <= o_level;
   end

   assign o_rise = o_level & ~level_d;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts i_sig rising edges over GATE_CYCLES clks, one-shot or back-to-back windows.
// Results sit on a valid/ready register; a new result overwrites an unaccepted one and pulses o_drop.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ      = DEFAULT_CLK_HZ,
   parameter int GATE_CYCLES = CLK_HZ,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_sig,
   input  logic             i_start,
   input  logic             i_cont,
   input  logic             i_ready,
   output logic [CNT_W-1:0] o_count,
   output logic             o_ovf,
   output logic             o_valid,
   output logic             o_drop,
   output logic             o_busy
);

   localparam int GATE_W = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   logic [0:0]       state;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic             sat;
   logic             sig_level;
   logic             sig_rise;
   logic             edge_hit;
   logic             cnt_full;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;

   sig_sync_edge u_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (i_sig),
      .o_level (sig_level),
      .o_rise  (sig_rise)
   );

   // A rise always coincides with a high level, so the qualifier never masks a real edge.
   assign edge_hit = sig_rise & sig_level;
   assign cnt_full = &edge_cnt;
   assign cnt_next = (edge_hit && !cnt_full) ? edge_cnt + CNT_W'(1) : edge_cnt;
   assign ovf_next = sat | (edge_hit & cnt_full);
   assign o_busy   = (state == ST_GATE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         gate_cnt <= '0;
         edge_cnt <= '0;
         sat      <= 1'b0;
         o_count  <= '0;
         o_ovf    <= 1'b0;
         o_valid  <= 1'b0;
         o_drop   <= 1'b0;
      end else begin
         o_drop <= 1'b0;
         if (o_valid && i_ready)
            o_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (i_start || i_cont) begin
                  state    <= ST_GATE;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
               end
            end
            default: begin
               if (gate_cnt == GATE_LAST) begin
                  // Latch overrides a same-cycle accept, so o_valid stays high with fresh data.
                  o_count  <= cnt_next;
                  o_ovf    <= ovf_next;
                  o_valid  <= 1'b1;
                  o_drop   <= o_valid & ~i_ready;
                  gate_cnt <= '0;
                  edge_cnt <= '0;
                  sat      <= 1'b0;
                  if (!i_cont)
                     state <= ST_IDLE;
               end else begin
                  gate_cnt <= gate_cnt + GATE_W'(1);
                  edge_cnt <= cnt_next;
                  sat      <= ovf_next;
               end
            end
         endcase
      end
   end

endmodule
